// File: rtl/dibu_loader_top.sv
// dibu_loader_top: dibu core with a byte-stream program loader, a run-control FSM
// and a synchronised/registered IO path.
module datapath #(
    parameter int IO_W        = 4,
    parameter int CODE_W      = 16,
    parameter int CODE_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   code_w_en,
    input  logic [CODE_ADDR_W-1:0] code_addr_in,
    input  logic [CODE_W-1:0]      code_in,
    input  logic [IO_W-1:0]        io_in,
    output logic [IO_W-1:0]        io_out
);
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_IN   = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_PASS = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;

    logic [CODE_W-1:0]      mem [2**CODE_ADDR_W];
    logic [CODE_W-1:0]      instr;
    logic [3:0]             op;
    logic [IO_W-1:0]        imm, acc, acc_nx, out_q, out_nx;
    logic [CODE_ADDR_W-1:0] pc, pc_nx, target;
    logic                   unused_bits;

    assign instr       = mem[pc];
    assign op          = instr[CODE_W-1 -: 4];
    assign imm         = instr[IO_W-1:0];
    assign target      = instr[CODE_ADDR_W-1:0];
    assign unused_bits = ^instr;
    assign io_out      = out_q;

    // Program memory survives reset so a core can be restarted without reloading
    always_ff @(posedge clk)
        if (code_w_en) mem[code_addr_in] <= code_in;

    always_comb begin
        pc_nx  = pc + 1'b1;
        acc_nx = acc;
        out_nx = out_q;
        case (op)
            OP_LDI:  acc_nx = imm;
            OP_IN:   acc_nx = io_in;
            OP_OUT:  out_nx = acc;
            OP_ADD:  acc_nx = acc + imm;
            OP_XOR:  acc_nx = acc ^ imm;
            OP_JMP:  pc_nx  = target;
            OP_PASS: out_nx = io_in;
            OP_JZ:   pc_nx  = (acc == '0) ? target : pc + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc    <= '0;
            acc   <= '0;
            out_q <= '0;
        end else if (!run) begin
            pc <= '0;
        end else begin
            pc    <= pc_nx;
            acc   <= acc_nx;
            out_q <= out_nx;
        end
endmodule

module dibu_loader_top #(
    parameter int IO_W        = 4,
    parameter int CODE_W      = 16,
    parameter int CODE_ADDR_W = 8,
    parameter int AUTORUN     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_req,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    input  logic [IO_W-1:0]      io_in,
    output logic [IO_W-1:0]      io_out,
    output logic                 running,
    output logic                 load_err,
    output logic [CODE_ADDR_W:0] words_loaded
);
    localparam int BPW   = CODE_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx;
    logic [CODE_ADDR_W-1:0] addr, code_addr;
    logic [CODE_W-1:0]      wbuf, word_nx, code_word;
    logic                   code_w_en, fin, accept, last_byte, entry;
    logic [IO_W-1:0]        io_meta, io_sync, dp_out;

    assign ld_ready  = (state == LOAD) && !fin;
    assign accept    = ld_valid && ld_ready;
    assign last_byte = idx == IDX_W'(BPW - 1);
    assign entry     = (state != LOAD) && (state_nx == LOAD);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = load_req ? LOAD : IDLE;
            LOAD:    state_nx = fin ? RUN : (accept && ld_last && !last_byte) ? IDLE : LOAD;
            RUN:     state_nx = load_req ? LOAD : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= (AUTORUN != 0) ? RUN : IDLE;
        else        state <= state_nx;

    // Little-endian assembly: byte k of a word lands in bits [8k+7:8k]
    always_comb begin
        word_nx = wbuf;
        word_nx[{idx, 3'b000} +: 8] = ld_data;
    end

    // fin holds ld_ready low for the write cycle before the switch to RUN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx          <= '0;
            addr         <= '0;
            wbuf         <= '0;
            code_word    <= '0;
            code_addr    <= '0;
            code_w_en    <= 1'b0;
            fin          <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else if (entry) begin
            idx          <= '0;
            addr         <= '0;
            code_w_en    <= 1'b0;
            fin          <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            code_w_en <= accept && last_byte;
            fin       <= accept && last_byte && (ld_last || addr == '1);
            if (accept && last_byte) begin
                code_word <= word_nx;
                code_addr <= addr;
                addr      <= addr + 1'b1;
                idx       <= '0;
            end else if (accept) begin
                wbuf <= word_nx;
                idx  <= idx + 1'b1;
            end
            if (accept && ld_last && !last_byte) load_err <= 1'b1;
            if (code_w_en) words_loaded <= words_loaded + 1'b1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            running <= 1'b0;
            io_meta <= '0;
            io_sync <= '0;
            io_out  <= '0;
        end else begin
            running <= state_nx == RUN;
            io_meta <= io_in;
            io_sync <= io_meta;
            io_out  <= (state_nx == RUN) ? dp_out : '0;
        end

    datapath #(
        .IO_W(IO_W),
        .CODE_W(CODE_W),
        .CODE_ADDR_W(CODE_ADDR_W)
    ) u_dp (
        .clk(clk),
        .rst_n(rst_n),
        .run(running),
        .code_w_en(code_w_en),
        .code_addr_in(code_addr),
        .code_in(code_word),
        .io_in(io_sync),
        .io_out(dp_out)
    );
endmodule

// File: tb/tb_dibu_loader_top.sv
// tb_dibu_loader_top: directed vector table plus hand sequences for the loader,
// run control, IO latency and reset behaviour.
module tb_dibu_loader_top;
    logic       clk = 1'b0;
    logic       rst_n, load_req, ld_valid, ld_last;
    logic [7:0] ld_data;
    logic [3:0] io_in, io_out, ar_io_out;
    logic       ld_ready, running, load_err, ar_ld_ready, ar_running, ar_load_err;
    logic [4:0] words_loaded, ar_words_loaded;
    int         total = 0, bad = 0, n_acc = 0;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic       lr, v;
        logic [7:0] d;
        logic       l, e_rdy, e_run, e_wen, e_err;
        logic [4:0] e_wl;
    } vec_t;
    vec_t tv[14];

    always #5 clk = ~clk;

    dibu_loader_top #(.IO_W(4), .CODE_W(16), .CODE_ADDR_W(4), .AUTORUN(0)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .io_in(io_in),
        .io_out(io_out), .running(running), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    dibu_loader_top #(.IO_W(4), .CODE_W(16), .CODE_ADDR_W(4), .AUTORUN(1)) dut_ar (
        .clk(clk), .rst_n(rst_n), .load_req(1'b0), .ld_valid(1'b0),
        .ld_data(8'h00), .ld_last(1'b0), .ld_ready(ar_ld_ready), .io_in(io_in),
        .io_out(ar_io_out), .running(ar_running), .load_err(ar_load_err),
        .words_loaded(ar_words_loaded)
    );

    always @(posedge clk) if (dut.code_w_en) wq.push_back('{dut.code_addr, dut.code_word});
    always @(posedge clk) if (ld_valid && ld_ready) n_acc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int n0, good;
        //        lr v  data  l  rdy run wen err wl
        tv[0]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 8'h34, 0, 1, 0, 0, 0, 0};
        tv[2]  = '{0, 1, 8'h12, 0, 1, 0, 1, 0, 0};
        tv[3]  = '{0, 1, 8'h78, 0, 1, 0, 0, 0, 1};
        tv[4]  = '{0, 1, 8'h56, 1, 0, 0, 1, 0, 1};
        tv[5]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 2};
        tv[6]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 2};
        tv[7]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        tv[8]  = '{0, 1, 8'h11, 0, 1, 0, 0, 0, 0};
        tv[9]  = '{0, 1, 8'h22, 0, 1, 0, 1, 0, 0};
        tv[10] = '{0, 1, 8'h33, 1, 0, 0, 0, 1, 1};
        tv[11] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 1};
        tv[12] = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        tv[13] = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0};

        rst_n = 1'b0; load_req = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0; io_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst ld_ready", ld_ready, 0);
        chk("rst running", running, 0);
        chk("rst io_out", io_out, 0);
        chk("rst load_err", load_err, 0);
        chk("rst words", words_loaded, 0);
        chk("rst autorun running", ar_running, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle running", running, 0);
        chk("idle ld_ready", ld_ready, 0);
        chk("autorun running after release", ar_running, 1);

        foreach (tv[i]) begin
            load_req = tv[i].lr; ld_valid = tv[i].v; ld_data = tv[i].d; ld_last = tv[i].l;
            @(negedge clk);
            chk($sformatf("vec%0d ld_ready", i), ld_ready, tv[i].e_rdy);
            chk($sformatf("vec%0d running", i), running, tv[i].e_run);
            chk($sformatf("vec%0d code_w_en", i), dut.code_w_en, tv[i].e_wen);
            chk($sformatf("vec%0d load_err", i), load_err, tv[i].e_err);
            chk($sformatf("vec%0d words", i), words_loaded, tv[i].e_wl);
        end
        chk("vec writes", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("w0 addr", wq[0].a, 0); chk("w0 data", wq[0].d, 16'h1234);
            chk("w1 addr", wq[1].a, 1); chk("w1 data", wq[1].d, 16'h5678);
            chk("w2 addr", wq[2].a, 0); chk("w2 data", wq[2].d, 16'h2211);
        end

        // Full image of PASS words without ld_last; stops at the top address
        load_req = 1'b0;
        wq.delete();
        n0 = n_acc;
        for (int i = 0; i < 34; i++) begin
            ld_valid = 1'b1; ld_data = i[0] ? 8'h70 : 8'h00; ld_last = 1'b0;
            @(negedge clk);
            if (i == 30) chk("stream rdy before byte 32", ld_ready, 1);
            if (i == 31) chk("stream rdy after byte 32", ld_ready, 0);
        end
        ld_valid = 1'b0;
        @(negedge clk);
        chk("stream accepted", n_acc - n0, 32);
        chk("stream writes", wq.size(), 16);
        good = 0;
        foreach (wq[k]) if (wq[k].a == 4'(k) && wq[k].d == 16'h7000) good++;
        chk("stream addr/data", good, 16);
        chk("stream running", running, 1);
        chk("stream words", words_loaded, 16);
        chk("stream ld_ready", ld_ready, 0);
        chk("stream load_err", load_err, 0);

        chk("io before", io_out, 0);
        io_in = 4'hA;
        @(negedge clk); chk("sync 1 cycle", dut.io_sync, 4'h0);
        @(negedge clk); chk("sync 2 cycles", dut.io_sync, 4'hA);
        @(negedge clk); chk("io_out 3 cycles", io_out, 4'h0);
        @(negedge clk); chk("io_out 4 cycles", io_out, 4'hA);
        io_in = 4'h5;
        repeat (4) @(negedge clk);
        chk("io_out follow 5", io_out, 4'h5);

        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("reload running", running, 0);
        chk("reload io_out", io_out, 0);
        chk("reload ld_ready", ld_ready, 1);
        wq.delete();
        ld_valid = 1'b1; ld_data = 8'h00;
        @(negedge clk);
        ld_data = 8'h70; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        chk("reload writes", wq.size(), 1);
        if (wq.size() == 1) chk("reload addr", wq[0].a, 0);
        chk("reload running", running, 1);
        chk("reload words", words_loaded, 1);

        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0; ld_valid = 1'b1; ld_data = 8'h55;
        @(negedge clk);
        wq.delete();
        ld_data = 8'h66; rst_n = 1'b0; io_in = 4'hF;
        repeat (3) @(negedge clk);
        chk("midrst writes", wq.size(), 0);
        chk("midrst ld_ready", ld_ready, 0);
        chk("midrst running", running, 0);
        chk("midrst io_out", io_out, 0);
        chk("midrst load_err", load_err, 0);
        chk("midrst words", words_loaded, 0);
        chk("midrst ar running", ar_running, 0);
        ld_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post rst ar running", ar_running, 1);
        chk("post rst running", running, 0);
        chk("post rst ld_ready", ld_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
